// File: rtl/ahb3lite_sram_1rw.sv
// ahb3lite_sram_1rw: zero-wait-state AHB3-Lite slave around a single-port byte-addressable SRAM.
// Define AHB3_SRAM_ADDR_ERR_EN to answer out-of-range addresses with a two-cycle ERROR instead of wrapping.
module ahb3lite_sram_1rw #(
    parameter int MEM_SIZE   = 4096,
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    output logic                  HREADYOUT,
    input  logic                  HREADY,
    output logic                  HRESP
);
    localparam int AW    = $clog2(MEM_SIZE);
    localparam int WORDS = MEM_SIZE / 4;

    logic [HDATA_SIZE-1:0] mem [WORDS];
    logic [HDATA_SIZE-1:0] rd_word;
    logic [AW-3:0]         idx, dp_idx;
    logic [3:0]            be, dp_be;
    logic                  accept, oor, acc_ok, dp_valid, dp_write, unused;

    assign accept = HSEL && HREADY && HTRANS[1];
    assign acc_ok = accept && !oor;
    assign idx    = HADDR[AW-1:2];
    assign be     = (HSIZE[2] || HSIZE[1]) ? 4'hf :
                    HSIZE[0] ? (HADDR[1] ? 4'hc : 4'h3) : 4'b0001 << HADDR[1:0];

    // Forward lanes still in flight from the write data phase into a same-word read.
    always_comb begin
        rd_word = mem[idx];
        for (int i = 0; i < 4; i++)
            if (dp_valid && dp_write && dp_idx == idx && dp_be[i])
                rd_word[8*i +: 8] = HWDATA[8*i +: 8];
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_be    <= '0;
            HRDATA   <= '0;
        end else begin
            dp_valid <= acc_ok;
            if (acc_ok) begin
                dp_write <= HWRITE;
                dp_idx   <= idx;
                dp_be    <= be;
            end
            if (acc_ok && !HWRITE)
                HRDATA <= rd_word;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn && dp_valid && dp_write)
            for (int i = 0; i < 4; i++)
                if (dp_be[i])
                    mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
    end

`ifdef AHB3_SRAM_ADDR_ERR_EN
    typedef enum logic [1:0] {S_OK, S_ERR1, S_ERR2} state_t;
    state_t state, state_nxt;

    assign oor    = |HADDR[HADDR_SIZE-1:AW];
    assign unused = ^{HBURST, HPROT};

    always_ff @(posedge HCLK) begin
        state <= HRESETn ? state_nxt : S_OK;
    end

    always_comb begin
        state_nxt = state == S_ERR1 ? S_ERR2 : (accept && oor) ? S_ERR1 : S_OK;
    end

    always_comb begin
        HREADYOUT = state != S_ERR1;
        HRESP     = state != S_OK;
    end
`else
    assign oor       = 1'b0;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign unused    = ^{HBURST, HPROT, HADDR[HADDR_SIZE-1:AW]};
`endif
endmodule

// File: tb/tb_ahb3lite_sram_1rw.sv
// tb_ahb3lite_sram_1rw: scoreboard bench for the AHB3-Lite SRAM slave with a byte-level memory model.
module tb_ahb3lite_sram_1rw;
    localparam int MEM_SIZE = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        write = 1'b0;
    logic [2:0]  size = 3'd2;
    logic [2:0]  burst = 3'd0;
    logic [3:0]  prot = 4'd0;
    logic [1:0]  trans = 2'd0;
    logic        readyout;
    logic        hready;
    logic        resp;

    int          checks = 0;
    int          errors = 0;
    logic        chk_resp = 1'b1;
    logic [7:0]  mm [MEM_SIZE];
    logic [31:0] q [$];
    logic [31:0] nxt_wdata = '0;
    logic        pw_valid = 1'b0;
    logic [31:0] pw_addr = '0;
    logic [2:0]  pw_size = '0;

    assign hready = readyout;

    ahb3lite_sram_1rw #(.MEM_SIZE(MEM_SIZE)) dut (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel), .HADDR(addr), .HWDATA(wdata),
        .HRDATA(rdata), .HWRITE(write), .HSIZE(size), .HBURST(burst), .HPROT(prot),
        .HTRANS(trans), .HREADYOUT(readyout), .HREADY(hready), .HRESP(resp)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int b;
        b = int'(a % MEM_SIZE) & ~3;
        return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int b;
        logic [1:0] off;
        b = int'(a % MEM_SIZE) & ~3;
        off = a[1:0];
        for (int j = 0; j < 4; j++) begin
            if (sz == 3'd0 ? j == int'(off) : sz == 3'd1 ? (j / 2) == int'(off[1]) : 1'b1)
                mm[b+j] = d[8*j +: 8];
        end
    endtask

    // One bus cycle: address phase of this beat, data phase (HWDATA) of the previous one.
    task automatic cycle(input logic s, input logic [1:0] t, input logic w,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic acc;
        logic [31:0] exp;
        sel = s; trans = t; write = w; size = sz; addr = a; wdata = nxt_wdata;
        if (pw_valid) model_write(pw_addr, pw_size, nxt_wdata);
        acc = s && t[1];
`ifdef AHB3_SRAM_ADDR_ERR_EN
        acc = acc && a < MEM_SIZE;
`endif
        pw_valid = acc && w; pw_addr = a; pw_size = sz;
        if (acc && !w) q.push_back(model_word(a));
        nxt_wdata = wd;
        @(posedge clk); #1;
        if (acc && !w) begin
            exp = q.pop_front();
            checks++;
            if (rdata !== exp) begin
                errors++;
                $display("FAIL read@%h: got %h want %h", a, rdata, exp);
            end
        end
        if (chk_resp) begin
            checks++;
            if (readyout !== 1'b1 || resp !== 1'b0) begin
                errors++;
                $display("FAIL okay_resp@%h: got ready=%b resp=%b want ready=1 resp=0", a, readyout, resp);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rdata !== 32'h0 || readyout !== 1'b1 || resp !== 1'b0) begin
            errors++;
            $display("FAIL reset: got rdata=%h ready=%b resp=%b want 0/1/0", rdata, readyout, resp);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        cycle(1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        idle();
        cycle(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
        idle();
        idle();
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hold: got %h want %h", rdata, 32'hDEADBEEF);
        end
    endtask

    task automatic test_byte_half();
        cycle(1'b1, 2'd2, 1'b1, 3'd0, 32'h20, {4{8'h11}});
        cycle(1'b1, 2'd2, 1'b1, 3'd0, 32'h21, {4{8'h22}});
        cycle(1'b1, 2'd2, 1'b1, 3'd0, 32'h22, {4{8'h33}});
        cycle(1'b1, 2'd2, 1'b1, 3'd0, 32'h23, {4{8'h44}});
        idle();
        cycle(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0);
        cycle(1'b1, 2'd2, 1'b1, 3'd1, 32'h22, {2{16'hABCD}});
        idle();
        cycle(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0);
        idle();
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 2'd2, 1'b1, 3'd2, 32'h30, 32'h00000005);
        cycle(1'b1, 2'd2, 1'b0, 3'd2, 32'h30, 32'h0);
        cycle(1'b1, 2'd2, 1'b1, 3'd0, 32'h31, {4{8'h9C}});
        cycle(1'b1, 2'd2, 1'b0, 3'd2, 32'h30, 32'h0);
        idle();
    endtask

    task automatic test_burst();
        cycle(1'b1, 2'd2, 1'b1, 3'd2, 32'h40, 32'd1);
        cycle(1'b1, 2'd3, 1'b1, 3'd2, 32'h44, 32'd2);
        cycle(1'b1, 2'd1, 1'b1, 3'd2, 32'h48, 32'hBAD0BAD0);
        cycle(1'b1, 2'd3, 1'b1, 3'd2, 32'h48, 32'd3);
        cycle(1'b1, 2'd3, 1'b1, 3'd2, 32'h4C, 32'd4);
        idle();
        cycle(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0);
        cycle(1'b1, 2'd3, 1'b0, 3'd2, 32'h44, 32'h0);
        cycle(1'b1, 2'd3, 1'b0, 3'd2, 32'h48, 32'h0);
        cycle(1'b1, 2'd3, 1'b0, 3'd2, 32'h4C, 32'h0);
        idle();
    endtask

    task automatic test_no_access();
        cycle(1'b1, 2'd2, 1'b1, 3'd2, 32'h50, 32'hCAFEF00D);
        cycle(1'b1, 2'd0, 1'b1, 3'd2, 32'h50, 32'h11111111);
        cycle(1'b0, 2'd2, 1'b1, 3'd2, 32'h50, 32'h22222222);
        idle();
        cycle(1'b1, 2'd2, 1'b0, 3'd2, 32'h50, 32'h0);
        idle();
    endtask

    task automatic test_reset_drop();
        cycle(1'b1, 2'd2, 1'b1, 3'd2, 32'h60, 32'h12345678);
        cycle(1'b1, 2'd2, 1'b1, 3'd2, 32'h60, 32'hFFFFFFFF);
        rst_n = 1'b0; sel = 1'b0; trans = 2'd0; wdata = nxt_wdata;
        pw_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 2'd2, 1'b0, 3'd2, 32'h60, 32'h0);
        idle();
    endtask

    task automatic test_addr_range();
        cycle(1'b1, 2'd2, 1'b1, 3'd2, 32'h04, 32'h0A0A0A0A);
        idle();
`ifdef AHB3_SRAM_ADDR_ERR_EN
        chk_resp = 1'b0;
        cycle(1'b1, 2'd2, 1'b1, 3'd2, MEM_SIZE + 4, 32'h55AA55AA);
        checks++;
        if (readyout !== 1'b0 || resp !== 1'b1) begin
            errors++;
            $display("FAIL err_cycle1: got ready=%b resp=%b want ready=0 resp=1", readyout, resp);
        end
        idle();
        checks++;
        if (readyout !== 1'b1 || resp !== 1'b1) begin
            errors++;
            $display("FAIL err_cycle2: got ready=%b resp=%b want ready=1 resp=1", readyout, resp);
        end
        chk_resp = 1'b1;
`else
        cycle(1'b1, 2'd2, 1'b1, 3'd2, MEM_SIZE + 4, 32'h55AA55AA);
`endif
        idle();
        cycle(1'b1, 2'd2, 1'b0, 3'd2, 32'h04, 32'h0);
        idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_byte_half();
        test_back_to_back();
        test_burst();
        test_no_access();
        test_reset_drop();
        test_addr_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
